// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver: note/octave half-period lookup, boundary-aligned
// note changes, release that completes the last full cycle, and PWM volume gating.
module buzzer_tone_gen #(
   parameter int CNT_W = 18,
   parameter int VOL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_on,
   input  logic [3:0]       key,
   input  logic [1:0]       octave,
   input  logic [VOL_W-1:0] volume,
   output logic             buzzer,
   output logic             playing,
   output logic [3:0]       cur_key
);

   typedef enum logic [1:0] {IDLE, PLAY, STOP} state_t;

   state_t           state, state_nxt;
   logic             key_on_r;
   logic [3:0]       key_r;
   logic [1:0]       octave_r;
   logic [CNT_W-1:0] base, half;
   logic [CNT_W-1:0] cnt, cnt_nxt, cur_half, cur_half_nxt;
   logic [3:0]       cur_key_nxt;
   logic             tone, tone_nxt;
   logic [VOL_W-1:0] pwm_cnt;
   logic             valid, boundary, gate;

   always_comb begin
      case (key_r)
         4'd1:    base = CNT_W'(191110);
         4'd2:    base = CNT_W'(180388);
         4'd3:    base = CNT_W'(170265);
         4'd4:    base = CNT_W'(160705);
         4'd5:    base = CNT_W'(151685);
         4'd6:    base = CNT_W'(143172);
         4'd7:    base = CNT_W'(135137);
         4'd8:    base = CNT_W'(127551);
         4'd9:    base = CNT_W'(120395);
         4'd10:   base = CNT_W'(113636);
         4'd11:   base = CNT_W'(107259);
         4'd12:   base = CNT_W'(101238);
         default: base = '0;
      endcase
   end

   assign half     = base >> octave_r;
   assign valid    = key_on_r && (key_r != 4'd0) && (key_r <= 4'd12);
   assign boundary = (cnt == cur_half - CNT_W'(1));
   assign gate     = (volume == '1) || (pwm_cnt < volume);
   assign playing  = (state != IDLE);

   // PLAY and STOP share the running counter; valid alone decides whether a
   // boundary reloads the next note or winds the tone down.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      cur_half_nxt = cur_half;
      cur_key_nxt  = cur_key;
      tone_nxt     = tone;
      case (state)
         IDLE: begin
            cnt_nxt     = '0;
            tone_nxt    = 1'b0;
            cur_key_nxt = 4'd0;
            if (valid) begin
               cur_half_nxt = half;
               cur_key_nxt  = key_r;
               tone_nxt     = 1'b1;
               state_nxt    = PLAY;
            end
         end
         default: begin
            cnt_nxt   = cnt + CNT_W'(1);
            state_nxt = valid ? PLAY : STOP;
            if (boundary) begin
               cnt_nxt = '0;
               if (valid) begin
                  tone_nxt     = ~tone;
                  cur_half_nxt = half;
                  cur_key_nxt  = key_r;
               end else if (tone) begin
                  tone_nxt    = 1'b0;
                  cur_key_nxt = 4'd0;
                  state_nxt   = IDLE;
               end else begin
                  // finish one more high half so the last cycle is whole
                  tone_nxt = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_on_r <= 1'b0;
         key_r    <= 4'd0;
         octave_r <= 2'd0;
         state    <= IDLE;
         cnt      <= '0;
         cur_half <= '0;
         cur_key  <= 4'd0;
         tone     <= 1'b0;
         pwm_cnt  <= '0;
         buzzer   <= 1'b0;
      end else begin
         key_on_r <= key_on;
         key_r    <= key;
         octave_r <= octave;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         cur_half <= cur_half_nxt;
         cur_key  <= cur_key_nxt;
         tone     <= tone_nxt;
         pwm_cnt  <= pwm_cnt + VOL_W'(1);
         buzzer   <= tone_nxt && gate;
      end
   end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Bench for buzzer_tone_gen: half-period lengths measured on the pin against
// table/octave arithmetic, release behaviour, PWM pattern, rest codes and reset.
module tb_buzzer_tone_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_on;
   logic [3:0] key;
   logic [1:0] octave;
   logic [2:0] volume;
   logic       buzzer;
   logic       playing;
   logic [3:0] cur_key;

   int checks = 0;
   int failures = 0;
   int tbl [0:12] = '{0, 191110, 180388, 170265, 160705, 151685, 143172,
                      135137, 127551, 120395, 113636, 107259, 101238};

   buzzer_tone_gen #(.CNT_W(18), .VOL_W(3)) dut (
      .clk(clk), .rst(rst), .key_on(key_on), .key(key), .octave(octave),
      .volume(volume), .buzzer(buzzer), .playing(playing), .cur_key(cur_key)
   );

   always #5 clk = ~clk;

   function automatic int ref_half(input int k, input int o);
      if (k < 1 || k > 12) return 0;
      return tbl[k] >> o;
   endfunction

   // Counts consecutive cycles the pin holds lvl, starting at the current sample.
   task automatic run_len(input logic lvl, output int n);
      n = 0;
      while (buzzer === lvl && n < 60000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; key_on = 1'b1; key = 4'd5; octave = 2'd0; volume = 3'd7;
      repeat (3) @(negedge clk);
      checks++; if (buzzer !== 1'b0) begin failures++; $display("FAIL reset_buzzer got=%b exp=0", buzzer); end
      checks++; if (playing !== 1'b0) begin failures++; $display("FAIL reset_playing got=%b exp=0", playing); end
      checks++; if (cur_key !== 4'd0) begin failures++; $display("FAIL reset_cur_key got=%0d exp=0", cur_key); end
      key_on = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_rest();
      int codes [4] = '{0, 13, 14, 15};
      int c;
      c = codes[$urandom_range(0, 3)];
      key = 4'(c); key_on = 1'b1; octave = 2'(3);
      repeat (4) @(negedge clk);
      checks++; if (buzzer !== 1'b0) begin failures++; $display("FAIL rest_buzzer key=%0d got=%b exp=0", c, buzzer); end
      checks++; if (playing !== 1'b0) begin failures++; $display("FAIL rest_playing key=%0d got=%b exp=0", c, playing); end
      checks++; if (cur_key !== 4'd0) begin failures++; $display("FAIL rest_cur_key got=%0d exp=0", cur_key); end
      key_on = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Note change mid high half, then release during the low half.
   task automatic test_change_and_stop_low();
      int a, b, n;
      a = $urandom_range(10, 12);
      b = 10 + ((a - 10 + 1 + $urandom_range(0, 1)) % 3);
      volume = 3'd7; octave = 2'd3; key = 4'(a); key_on = 1'b1;
      @(negedge clk);
      checks++; if (buzzer !== 1'b0) begin failures++; $display("FAIL start_edge1 got=%b exp=0", buzzer); end
      @(negedge clk);
      checks++; if (buzzer !== 1'b1) begin failures++; $display("FAIL start_edge2 got=%b exp=1", buzzer); end
      checks++; if (playing !== 1'b1) begin failures++; $display("FAIL start_playing got=%b exp=1", playing); end
      checks++; if (cur_key !== 4'(a)) begin failures++; $display("FAIL start_cur_key got=%0d exp=%0d", cur_key, a); end
      repeat (100) @(negedge clk);
      key = 4'(b);
      run_len(1'b1, n);
      checks++; if (100 + n != ref_half(a, 3)) begin failures++; $display("FAIL high_half_old_key got=%0d exp=%0d", 100 + n, ref_half(a, 3)); end
      checks++; if (cur_key !== 4'(b)) begin failures++; $display("FAIL cur_key_reload got=%0d exp=%0d", cur_key, b); end
      repeat (50) @(negedge clk);
      key_on = 1'b0;
      run_len(1'b0, n);
      checks++; if (50 + n != ref_half(b, 3)) begin failures++; $display("FAIL low_half_new_key got=%0d exp=%0d", 50 + n, ref_half(b, 3)); end
      checks++; if (playing !== 1'b1) begin failures++; $display("FAIL extra_high_playing got=%b exp=1", playing); end
      run_len(1'b1, n);
      checks++; if (n != ref_half(b, 3)) begin failures++; $display("FAIL extra_high_half got=%0d exp=%0d", n, ref_half(b, 3)); end
      checks++; if (playing !== 1'b0) begin failures++; $display("FAIL stop_low_playing got=%b exp=0", playing); end
      checks++; if (cur_key !== 4'd0) begin failures++; $display("FAIL stop_low_cur_key got=%0d exp=0", cur_key); end
      repeat (20) @(negedge clk);
      checks++; if (buzzer !== 1'b0 || playing !== 1'b0) begin failures++; $display("FAIL idle_after_stop buzzer=%b playing=%b exp=0,0", buzzer, playing); end
   endtask

   task automatic test_stop_high();
      int c, n;
      c = $urandom_range(11, 12);
      volume = 3'd7; octave = 2'd2; key = 4'(c); key_on = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (buzzer !== 1'b1) begin failures++; $display("FAIL oct2_start got=%b exp=1", buzzer); end
      repeat (200) @(negedge clk);
      key_on = 1'b0;
      run_len(1'b1, n);
      checks++; if (200 + n != ref_half(c, 2)) begin failures++; $display("FAIL stop_high_half got=%0d exp=%0d", 200 + n, ref_half(c, 2)); end
      checks++; if (buzzer !== 1'b0) begin failures++; $display("FAIL stop_high_buzzer got=%b exp=0", buzzer); end
      checks++; if (playing !== 1'b0) begin failures++; $display("FAIL stop_high_playing got=%b exp=0", playing); end
      checks++; if (cur_key !== 4'd0) begin failures++; $display("FAIL stop_high_cur_key got=%0d exp=0", cur_key); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_volume_and_rst();
      logic smp [32];
      int ones, bad, rises;
      volume = 3'd7; octave = 2'd3; key = 4'd12; key_on = 1'b1;
      repeat (2) @(negedge clk);
      volume = 3'd3;
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin smp[i] = buzzer; @(negedge clk); end
      ones = 0; bad = 0; rises = 0;
      for (int i = 0; i < 8; i++) begin
         if (smp[i]) ones++;
         if (smp[i] && !smp[(i + 7) % 8]) rises++;
      end
      for (int i = 0; i < 24; i++) if (smp[i] !== smp[i + 8]) bad++;
      checks++; if (ones != 3) begin failures++; $display("FAIL pwm3_high_count got=%0d exp=3", ones); end
      checks++; if (rises != 1) begin failures++; $display("FAIL pwm3_contiguous rises=%0d exp=1", rises); end
      checks++; if (bad != 0) begin failures++; $display("FAIL pwm3_period8 mismatches=%0d exp=0", bad); end
      volume = 3'd0;
      @(negedge clk);
      ones = 0;
      for (int i = 0; i < 20; i++) begin if (buzzer !== 1'b0) ones++; @(negedge clk); end
      checks++; if (ones != 0) begin failures++; $display("FAIL vol0_buzzer high_samples=%0d exp=0", ones); end
      checks++; if (playing !== 1'b1) begin failures++; $display("FAIL vol0_playing got=%b exp=1", playing); end
      volume = 3'd7;
      @(negedge clk);
      checks++; if (buzzer !== 1'b1) begin failures++; $display("FAIL vol7_restore got=%b exp=1", buzzer); end
      rst = 1'b1; key_on = 1'b0;
      @(negedge clk);
      checks++; if (buzzer !== 1'b0 || playing !== 1'b0 || cur_key !== 4'd0) begin
         failures++; $display("FAIL midnote_rst buzzer=%b playing=%b cur_key=%0d exp=0,0,0", buzzer, playing, cur_key);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (buzzer !== 1'b0 || playing !== 1'b0) begin failures++; $display("FAIL post_rst_idle buzzer=%b playing=%b exp=0,0", buzzer, playing); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_rest();
      test_change_and_stop_low();
      test_stop_high();
      test_volume_and_rst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
